// File: rtl/sign_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sign_pkg
//  Description : Field widths, derived-size helpers and FSM state encoding
//                shared by the signature stream packer.
//  Revision    : 1.0  initial release
// ============================================================================
package sign_pkg;

    localparam int N_PARTY_DEF = 4;
    localparam int HASH_W_DEF  = 256;
    localparam int SALT_W_DEF  = 256;
    localparam int CSTAR_W_DEF = 256;
    localparam int SEEDT_W_DEF = 128;
    localparam int MSG_W_DEF   = 512;
    localparam int SEEDL_W_DEF = 7680;
    localparam int AUX_W_DEF   = 1024;
    localparam int WORD_W_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Total number of bits in the flat signature image.
    function automatic int calc_sig_w(input int n_party, input int hash_w,
                                      input int salt_w, input int cstar_w,
                                      input int seedt_w, input int msg_w,
                                      input int seedl_w, input int aux_w);
        return hash_w + salt_w + cstar_w + seedt_w
               + n_party * (msg_w + seedl_w + aux_w);
    endfunction

    // Words needed to carry sig_w bits; the last one may be partial.
    function automatic int calc_num_words(input int sig_w, input int word_w);
        return (sig_w + word_w - 1) / word_w;
    endfunction

    // Index width, never narrower than one bit.
    function automatic int calc_idx_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sign_word_sel.sv
`default_nettype none
// ============================================================================
//  Module      : sign_word_sel
//  Description : Combinational MSB-first word slicer. The image is padded on
//                the right with zeros so the final partial word is
//                left-aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module sign_word_sel #(
    parameter int SIG_W     = 37760,
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 590,
    parameter int IDX_W     = 10
) (
    input  logic [SIG_W-1:0]  i_sig,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [WORD_W-1:0] o_word
);

    localparam int PAD_W = NUM_WORDS * WORD_W;

    logic [PAD_W-1:0]  w_padded;
    logic [WORD_W-1:0] w_words [NUM_WORDS];

    // Left-justify the image inside a whole number of words.
    assign w_padded = PAD_W'(i_sig) << (PAD_W - SIG_W);

    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
            assign w_words[k] = w_padded[PAD_W-1-k*WORD_W -: WORD_W];
        end
    endgenerate

    assign o_word = w_words[i_idx];

endmodule
`default_nettype wire

// File: rtl/sign_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sign_stream_packer
//  Description : Streams a finished signature {h_t, salt, C_star,
//                seed_triangle, Z[0..N_PARTY-1]} as WORD_W-bit words over a
//                valid/ready handshake with last/done signalling.
//  Revision    : 1.0  initial release
// ============================================================================
module sign_stream_packer
    import sign_pkg::*;
#(
    parameter  int N_PARTY   = N_PARTY_DEF,
    parameter  int HASH_W    = HASH_W_DEF,
    parameter  int SALT_W    = SALT_W_DEF,
    parameter  int CSTAR_W   = CSTAR_W_DEF,
    parameter  int SEEDT_W   = SEEDT_W_DEF,
    parameter  int MSG_W     = MSG_W_DEF,
    parameter  int SEEDL_W   = SEEDL_W_DEF,
    parameter  int AUX_W     = AUX_W_DEF,
    parameter  int WORD_W    = WORD_W_DEF,
    localparam int SIG_W     = calc_sig_w(N_PARTY, HASH_W, SALT_W, CSTAR_W,
                                          SEEDT_W, MSG_W, SEEDL_W, AUX_W),
    localparam int NUM_WORDS = calc_num_words(SIG_W, WORD_W),
    localparam int IDX_W     = calc_idx_w(NUM_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [HASH_W-1:0]          h_t_i,
    input  logic [SALT_W-1:0]          salt_i,
    input  logic [CSTAR_W-1:0]         C_star_i,
    input  logic [SEEDT_W-1:0]         seed_triangle_i,
    input  logic [N_PARTY*MSG_W-1:0]   msgs_i,
    input  logic [N_PARTY*SEEDL_W-1:0] seed_lambda_i,
    input  logic [N_PARTY*AUX_W-1:0]   aux_triangle_i,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [IDX_W-1:0]           word_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int             Z_W        = MSG_W + SEEDL_W + AUX_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_next_idx;
    logic [N_PARTY*Z_W-1:0] w_parties;
    logic [SIG_W-1:0]       w_sig;
    logic [WORD_W-1:0]      w_word;
    logic                   w_xfer;

    // Party 0 sits in the most-significant slice of every per-party bus.
    generate
        for (genvar p = 0; p < N_PARTY; p++) begin : g_party
            assign w_parties[(N_PARTY-p)*Z_W-1 -: Z_W] = {
                msgs_i[(N_PARTY-p)*MSG_W-1 -: MSG_W],
                seed_lambda_i[(N_PARTY-p)*SEEDL_W-1 -: SEEDL_W],
                aux_triangle_i[(N_PARTY-p)*AUX_W-1 -: AUX_W]
            };
        end
    endgenerate

    // Inputs are held by the producer while busy, so no capture register.
    assign w_sig = {h_t_i, salt_i, C_star_i, seed_triangle_i, w_parties};

    sign_word_sel #(
        .SIG_W     (SIG_W),
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_word_sel (
        .i_sig  (w_sig),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    // All outputs derive from registers so an async reset clears them at once.
    assign out_valid = (r_state == STREAM);
    assign busy      = out_valid;
    assign done      = (r_state == DONE);
    assign word_idx  = r_idx;
    assign out_last  = out_valid && (r_idx == c_LAST_IDX);
    assign out_data  = out_valid ? w_word : '0;
    assign w_xfer    = out_valid && out_ready;

    // Next-state and word-counter logic; abort outranks a same-cycle transfer.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_next_state = STREAM;
                    w_next_idx   = '0;
                end
            end
            STREAM: begin
                if (abort) begin
                    w_next_state = IDLE;
                    w_next_idx   = '0;
                end else if (w_xfer) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_next_state = DONE;
                        w_next_idx   = '0;
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (abort || !start) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    // State and word-index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_stream_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sign_stream_packer
//  Description : Self-checking bench for sign_stream_packer (64- and 96-bit
//                word instances) against a bit-level signature image model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sign_stream_packer;

    localparam int N_PARTY = 4;
    localparam int HASH_W  = 256;
    localparam int SALT_W  = 256;
    localparam int CSTAR_W = 256;
    localparam int SEEDT_W = 128;
    localparam int MSG_W   = 512;
    localparam int SEEDL_W = 7680;
    localparam int AUX_W   = 1024;
    localparam int SIG_W   = 37760;
    localparam int NW      = 590;
    localparam int NW96    = 394;
    localparam int LIMIT   = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b1;
    logic start96 = 1'b0;
    logic out_ready96 = 1'b1;

    logic [HASH_W-1:0]          h_t;
    logic [SALT_W-1:0]          salt;
    logic [CSTAR_W-1:0]         cstar;
    logic [SEEDT_W-1:0]         seedt;
    logic [N_PARTY*MSG_W-1:0]   msgs;
    logic [N_PARTY*SEEDL_W-1:0] seedl;
    logic [N_PARTY*AUX_W-1:0]   aux;

    logic [63:0] out_data;
    logic        out_valid, out_last, busy, done;
    logic [9:0]  word_idx;
    logic [95:0] out_data96;
    logic        out_valid96, out_last96, busy96, done96;
    logic [8:0]  word_idx96;

    logic [SIG_W-1:0] sig_img;
    logic [63:0]      exp_words [NW];
    logic [95:0]      exp96 [NW96];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    sign_stream_packer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .h_t_i(h_t), .salt_i(salt), .C_star_i(cstar), .seed_triangle_i(seedt),
        .msgs_i(msgs), .seed_lambda_i(seedl), .aux_triangle_i(aux),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .word_idx(word_idx), .busy(busy), .done(done)
    );

    sign_stream_packer #(.WORD_W(96)) dut96 (
        .clk(clk), .reset(reset), .start(start96), .abort(abort),
        .h_t_i(h_t), .salt_i(salt), .C_star_i(cstar), .seed_triangle_i(seedt),
        .msgs_i(msgs), .seed_lambda_i(seedl), .aux_triangle_i(aux),
        .out_data(out_data96), .out_valid(out_valid96), .out_ready(out_ready96),
        .out_last(out_last96), .word_idx(word_idx96), .busy(busy96), .done(done96)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < HASH_W / 32; i++)  h_t[i*32 +: 32]   = $urandom;
        for (int i = 0; i < SALT_W / 32; i++)  salt[i*32 +: 32]  = $urandom;
        for (int i = 0; i < CSTAR_W / 32; i++) cstar[i*32 +: 32] = $urandom;
        for (int i = 0; i < SEEDT_W / 32; i++) seedt[i*32 +: 32] = $urandom;
        for (int i = 0; i < N_PARTY*MSG_W / 32; i++)   msgs[i*32 +: 32]  = $urandom;
        for (int i = 0; i < N_PARTY*SEEDL_W / 32; i++) seedl[i*32 +: 32] = $urandom;
        for (int i = 0; i < N_PARTY*AUX_W / 32; i++)   aux[i*32 +: 32]   = $urandom;
    endtask

    // Flat image by appending fields, then words read bit by bit MSB-first.
    task automatic build_model();
        logic [MSG_W-1:0]   m;
        logic [SEEDL_W-1:0] s;
        logic [AUX_W-1:0]   a;
        logic [95:0]        w;
        int                 pos;
        sig_img = SIG_W'(h_t);
        sig_img = (sig_img << SALT_W)  | SIG_W'(salt);
        sig_img = (sig_img << CSTAR_W) | SIG_W'(cstar);
        sig_img = (sig_img << SEEDT_W) | SIG_W'(seedt);
        for (int p = 0; p < N_PARTY; p++) begin
            m = MSG_W'(msgs >> ((N_PARTY-1-p)*MSG_W));
            s = SEEDL_W'(seedl >> ((N_PARTY-1-p)*SEEDL_W));
            a = AUX_W'(aux >> ((N_PARTY-1-p)*AUX_W));
            sig_img = (sig_img << MSG_W)   | SIG_W'(m);
            sig_img = (sig_img << SEEDL_W) | SIG_W'(s);
            sig_img = (sig_img << AUX_W)   | SIG_W'(a);
        end
        for (int k = 0; k < NW; k++) begin
            w = '0;
            for (int b = 0; b < 64; b++) begin
                pos = SIG_W - 1 - k*64 - b;
                w = {w[94:0], (pos >= 0) ? sig_img[16'(pos)] : 1'b0};
            end
            exp_words[k] = w[63:0];
        end
        for (int k = 0; k < NW96; k++) begin
            w = '0;
            for (int b = 0; b < 96; b++) begin
                pos = SIG_W - 1 - k*96 - b;
                w = {w[94:0], (pos >= 0) ? sig_img[16'(pos)] : 1'b0};
            end
            exp96[k] = w;
        end
    endtask

    // Stream monitor for the 64-bit instance.
    int         exp_next  = 0;
    int         xfers     = 0;
    int         run_words = 0;
    int         runs_done = 0;
    int         last_seen = -1;
    bit         prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [9:0]  prev_idx;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            exp_next   = 0;
            xfers      = 0;
            prev_stall = 1'b0;
        end else begin
            if (out_valid) begin
                check("stream_data", 128'(out_data), 128'(exp_words[word_idx]));
                check("stream_last", 128'(out_last), 128'(word_idx == 10'(NW-1)));
                check("stream_busy", 128'(busy), 128'(1));
                check("stream_done", 128'(done), 128'(0));
                if (prev_stall) begin
                    check("stall_data", 128'(out_data), 128'(prev_data));
                    check("stall_idx", 128'(word_idx), 128'(prev_idx));
                end
                if (out_ready && !abort) begin
                    check("stream_order", 128'(word_idx), 128'(exp_next));
                    xfers++;
                    if (out_last) begin
                        run_words = xfers;
                        runs_done++;
                        last_seen = int'(word_idx);
                        xfers     = 0;
                        exp_next  = 0;
                    end else begin
                        exp_next = int'(word_idx) + 1;
                    end
                end
                prev_stall = !out_ready && !abort;
                prev_data  = out_data;
                prev_idx   = word_idx;
            end else begin
                check("idle_data", 128'(out_data), 128'(0));
                check("idle_last", 128'(out_last), 128'(0));
                prev_stall = 1'b0;
            end
            if (abort) begin
                exp_next = 0;
                xfers    = 0;
            end
        end
    end

    task automatic run_until_done(output int cycles, input bit rand_ready);
        cycles = 0;
        forever begin
            if (rand_ready) out_ready = ($urandom_range(0, 99) >= 30);
            tick();
            cycles++;
            if (done) break;
            if (cycles > LIMIT) begin
                check("run_reaches_done", 128'(done), 128'(1));
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic run_until_idx(input int idx);
        int c;
        c = 0;
        while (!(out_valid && int'(word_idx) == idx)) begin
            tick();
            c++;
            if (c > LIMIT) begin
                check("reach_idx", 128'(word_idx), 128'(idx));
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int runs_before;
        int words96;
        int last96_idx;
        logic [95:0] last96_data;

        randomize_inputs();
        build_model();
        // Model pins computed directly from the input fields.
        check("model_word0", 128'(exp_words[0]), 128'(h_t[255:192]));
        check("model96_last", 128'(exp96[NW96-1]), 128'({aux[31:0], 64'h0}));

        repeat (3) tick();
        check("reset_outputs", 128'({out_valid, out_last, busy, done, word_idx, out_data}), 128'(0));
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: full-rate run, latency to done.
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        check("first_valid", 128'(out_valid), 128'(1));
        check("first_idx", 128'(word_idx), 128'(0));
        check("word0_is_ht_msb", 128'(out_data), 128'(h_t[255:192]));
        cyc = 1;
        while (!done && cyc <= LIMIT) begin
            tick();
            cyc++;
        end
        check("done_latency", 128'(cyc), 128'(591));
        check("last_word_idx", 128'(last_seen), 128'(589));
        check("words_in_run", 128'(run_words), 128'(NW));
        start = 1'b0;
        tick();
        check("back_to_idle", 128'({busy, done, out_valid}), 128'(0));

        // 2: random backpressure.
        start = 1'b1;
        run_until_done(cyc, 1'b1);
        check("words_bp_run", 128'(run_words), 128'(NW));
        start = 1'b0;
        tick();

        // 3: abort colliding with a transfer at word 100.
        start = 1'b1;
        run_until_idx(100);
        out_ready = 1'b1;
        abort = 1'b1;
        start = 1'b0;
        tick();
        check("abort_state", 128'({out_valid, done, busy, word_idx}), 128'(0));
        abort = 1'b0;
        tick();
        check("abort_no_done", 128'(done), 128'(0));
        start = 1'b1;
        tick();
        check("restart_idx", 128'(word_idx), 128'(0));
        check("restart_data", 128'(out_data), 128'(h_t[255:192]));
        run_until_done(cyc, 1'b0);
        check("restart_words", 128'(run_words), 128'(NW));

        // 4: start held high past done, with a fresh data pattern.
        start = 1'b0;
        tick();
        randomize_inputs();
        build_model();
        start = 1'b1;
        run_until_done(cyc, 1'b0);
        runs_before = runs_done;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("held_done", 128'(done), 128'(1));
            check("held_no_valid", 128'(out_valid), 128'(0));
        end
        start = 1'b0;
        tick();
        check("drop_start_idle", 128'(done), 128'(0));
        start = 1'b1;
        run_until_done(cyc, 1'b0);
        check("second_run_latency", 128'(cyc), 128'(591));
        check("second_run_count", 128'(runs_done - runs_before), 128'(1));
        check("second_run_words", 128'(run_words), 128'(NW));

        // 5: asynchronous reset at word 300.
        start = 1'b0;
        tick();
        start = 1'b1;
        run_until_idx(300);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              128'({out_valid, out_last, busy, done, word_idx, out_data}), 128'(0));
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        check("post_reset_idle", 128'({busy, done, out_valid, word_idx}), 128'(0));
        tick();
        check("post_reset_no_done", 128'(done), 128'(0));

        // 6: 96-bit instance.
        mon_en = 1'b0;
        out_ready96 = 1'b1;
        start96 = 1'b1;
        words96 = 0;
        last96_idx = -1;
        last96_data = '0;
        cyc = 0;
        forever begin
            tick();
            cyc++;
            if (done96) break;
            if (cyc > LIMIT) begin
                check("w96_reaches_done", 128'(done96), 128'(1));
                break;
            end
            if (out_valid96) begin
                check("w96_data", 128'(out_data96), 128'(exp96[word_idx96]));
                check("w96_last", 128'(out_last96), 128'(word_idx96 == 9'(NW96-1)));
                words96++;
                if (out_last96) begin
                    last96_idx  = int'(word_idx96);
                    last96_data = out_data96;
                end
            end
        end
        check("w96_num_words", 128'(words96), 128'(NW96));
        check("w96_last_idx", 128'(last96_idx), 128'(393));
        check("w96_last_word", 128'(last96_data), 128'({aux[31:0], 64'h0}));
        start96 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
